// File: rtl/word_serializer_pkg.sv
// Shared types and sizes for the 4-bit word serializer.
package word_serializer_pkg;

  localparam int IDX_W  = 2;
  localparam int WORD_W = 4;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/word_serializer_index_counter.sv
// Bit-index register for the serializer: load to the first index, step toward the final one.
module serializer_index_counter
  import word_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             reverse_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             final_o
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] first_idx, last_idx;

  always_comb begin
    first_idx = reverse_i ? '1 : '0;
    last_idx  = reverse_i ? '0 : '1;
    idx_d     = idx_q;
    if (load_i) begin
      idx_d = first_idx;
    end else if (step_i) begin
      idx_d = reverse_i ? (idx_q - ONE) : (idx_q + ONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o   = idx_q;
  assign final_o = (idx_q == last_idx);

endmodule

// File: rtl/word_serializer.sv
// Serializes a 4-bit word onto an external 4:1 mux by driving registered data/select lines.
// Define WORD_SERIALIZER_REVERSE_EN to emit bits in order 3,2,1,0 instead of 0,1,2,3.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              in0,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              addr0,
  output logic              addr1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

`ifdef WORD_SERIALIZER_REVERSE_EN
  localparam logic REVERSE = 1'b1;
`else
  localparam logic REVERSE = 1'b0;
`endif

  // The GAP counter counts down to zero, so it is loaded with one less than the gap length.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               idx_load, idx_step, idx_final;
  logic [IDX_W-1:0]   idx;

  serializer_index_counter u_index (
    .clk       (clk),
    .reset     (reset),
    .load_i    (idx_load),
    .step_i    (idx_step),
    .reverse_i (REVERSE),
    .idx_o     (idx),
    .final_o   (idx_final)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    gap_d    = gap_q;
    idx_load = 1'b0;
    idx_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d   = in_data;
          idx_load = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          idx_step = 1'b1;
          if (idx_final) begin
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
    end
  end

  // Reset forces IDLE, so in_ready must be masked while reset is still high.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == SEND);
  assign out_last  = (state_q == SEND) && idx_final;
  assign addr0     = idx[0];
  assign addr1     = idx[1];
  assign in0       = word_q[0];
  assign in1       = word_q[1];
  assign in2       = word_q[2];
  assign in3       = word_q[3];

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (GAP_CYCLES=2) driving a behavioural 4:1 mux model.
`timescale 1ns/1ps
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'b0000;
  logic       in0, in1, in2, in3;
  logic       addr0, addr1;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;

  int tests = 0;
  int fails = 0;

  logic [3:0] ins;
  logic [1:0] addr;
  logic       mux_out;

  assign ins     = {in3, in2, in1, in0};
  assign addr    = {addr1, addr0};
  assign mux_out = ins[addr];

  always #500 clk = ~clk;

  word_serializer #(.GAP_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .addr0     (addr0),
    .addr1     (addr1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Index presented at the k-th bit of a word.
  function automatic logic [1:0] seq_idx(input int k);
`ifdef WORD_SERIALIZER_REVERSE_EN
    return 2'(3 - k);
`else
    return 2'(k);
`endif
  endfunction

  task automatic test_reset();
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_out_last got %b want 0", out_last); end
    tests++; if (addr !== 2'b00) begin fails++; $display("FAIL rst_addr got %b want 00", addr); end
    tests++; if (ins !== 4'b0000) begin fails++; $display("FAIL rst_ins got %b want 0000", ins); end
    reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic_word(input logic [3:0] w, input string name);
    @(negedge clk);
    out_ready = 1'b1; in_data = w; in_valid = 1'b1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_accept in_ready got %b want 1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_valid[%0d] got %b want 1", name, k, out_valid); end
      tests++; if (addr !== seq_idx(k)) begin fails++; $display("FAIL %s_addr[%0d] got %b want %b", name, k, addr, seq_idx(k)); end
      tests++; if (mux_out !== w[seq_idx(k)]) begin fails++; $display("FAIL %s_mux[%0d] got %b want %b", name, k, mux_out, w[seq_idx(k)]); end
      tests++; if (out_last !== (k == 3)) begin fails++; $display("FAIL %s_last[%0d] got %b want %b", name, k, out_last, (k == 3)); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL %s_busy_ready[%0d] got %b want 0", name, k, in_ready); end
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) begin
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        fails++; $display("FAIL %s_gap[%0d] ready/valid got %b%b want 00", name, g, in_ready, out_valid);
      end
      @(negedge clk);
    end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_ready_again got %b want 1", name, in_ready); end
    tests++; if (ins !== w) begin fails++; $display("FAIL %s_word_kept got %b want %b", name, ins, w); end
  endtask

  task automatic test_stall();
    int n;
    @(negedge clk);
    out_ready = 1'b1; in_data = 4'b0110; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (addr !== seq_idx(0)) begin fails++; $display("FAIL stall_addr0 got %b want %b", addr, seq_idx(0)); end
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tests++; if (addr !== seq_idx(1) || mux_out !== 1'b1 || out_valid !== 1'b1) begin
        fails++; $display("FAIL stall_hold[%0d] addr/mux/valid got %b/%b/%b want %b/1/1", c, addr, mux_out, out_valid, seq_idx(1));
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    tests++; if (addr !== seq_idx(1)) begin fails++; $display("FAIL stall_release addr got %b want %b", addr, seq_idx(1)); end
    @(negedge clk);
    tests++; if (addr !== seq_idx(2) || mux_out !== 1'b1) begin
      fails++; $display("FAIL stall_resume addr/mux got %b/%b want %b/1", addr, mux_out, seq_idx(2));
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_drain timeout in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    out_ready = 1'b1; in_data = 4'b1111; in_valid = 1'b1;
    @(negedge clk);
    in_data = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tests++; if (mux_out !== 1'b1 || out_valid !== 1'b1) begin
        fails++; $display("FAIL b2b_first[%0d] mux/valid got %b/%b want 1/1", k, mux_out, out_valid);
      end
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) begin
      tests++; if (in_ready !== 1'b0 || ins !== 4'b1111) begin
        fails++; $display("FAIL b2b_gap[%0d] ready/ins got %b/%b want 0/1111", g, in_ready, ins);
      end
      @(negedge clk);
    end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_second_accept in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++; if (mux_out !== 1'b0 || out_valid !== 1'b1 || addr !== seq_idx(k)) begin
        fails++; $display("FAIL b2b_second[%0d] mux/valid/addr got %b/%b/%b want 0/1/%b", k, mux_out, out_valid, addr, seq_idx(k));
      end
      @(negedge clk);
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_drain timeout in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ignore_valid();
    int n;
    @(negedge clk);
    out_ready = 1'b1; in_data = 4'b1000; in_valid = 1'b1;
    @(negedge clk);
    in_data = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      tests++; if (ins !== 4'b1000 || in_ready !== 1'b0) begin
        fails++; $display("FAIL ignore_busy[%0d] ins/ready got %b/%b want 1000/0", c, ins, in_ready);
      end
      @(negedge clk);
    end
    tests++; if (in_ready !== 1'b1 || ins !== 4'b1000) begin
      fails++; $display("FAIL ignore_idle ready/ins got %b/%b want 1/1000", in_ready, ins);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (ins !== 4'b0101 || addr !== seq_idx(0)) begin
      fails++; $display("FAIL ignore_second ins/addr got %b/%b want 0101/%b", ins, addr, seq_idx(0));
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ignore_drain timeout in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_word();
    int n;
    @(negedge clk);
    out_ready = 1'b1; in_data = 4'b1100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (addr !== seq_idx(2)) begin fails++; $display("FAIL midrst_pre addr got %b want %b", addr, seq_idx(2)); end
    reset = 1'b1;
    #1;
    tests++; if (addr !== 2'b00) begin fails++; $display("FAIL midrst_addr got %b want 00", addr); end
    tests++; if (ins !== 4'b0000) begin fails++; $display("FAIL midrst_ins got %b want 0000", ins); end
    tests++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      fails++; $display("FAIL midrst_valid_last got %b%b want 00", out_valid, out_last);
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_quiet[%0d] out_valid got %b want 0", c, out_valid); end
    end
    in_data = 4'b0011; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || addr !== seq_idx(0) || mux_out !== in_data[seq_idx(0)]) begin
      fails++; $display("FAIL midrst_restart valid/addr/mux got %b/%b/%b want 1/%b/%b", out_valid, addr, mux_out, seq_idx(0), in_data[seq_idx(0)]);
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_drain timeout in_ready got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_word(4'b1010, "w1010");
    test_basic_word(4'b0001, "w0001");
    test_stall();
    test_back_to_back();
    test_ignore_valid();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
